regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16-bit register bank between several result producers: ALU, load unit and mul/div unit.
- Arbitrates each cycle with round-robin priority and drives a registered write strobe, address and data to the bank.
- Keeps a pending-write scoreboard so the multicycle controller can stall dependent instructions until a reserved register has been written.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- N_REGS, 8, number of registers in the bank (power of two)
- AW, 3, register address width, equal to log2(N_REGS)
- DW, 16, data width (signed two's complement, passed through unmodified)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- hold  in  1  controller stall; while high no grant is issued
- req_valid  in  N_REQ  per-requester write request
- req_addr  in  N_REQ*AW  destination addresses; requester i uses bits [i*AW +: AW]
- req_data  in  N_REQ*DW  write data; requester i uses bits [i*DW +: DW]
- req_ready  out  N_REQ  one-hot grant, combinational
- wr_en  out  1  registered write strobe to the register bank
- wr_addr  out  AW  registered write address
- wr_data  out  DW  registered write data
- rsv_en  in  1  reserve a destination register (issue-time)
- rsv_addr  in  AW  register to reserve
- pending  out  N_REGS  registered scoreboard; bit k set means register k has a write outstanding

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, pending=0, rr_ptr=0. req_ready=0 while reset is high.
- Handshake: a transfer occurs on a cycle where req_valid[i] and req_ready[i] are both high. Requesters hold addr/data stable until the transfer; no combinational path from req_ready to req_valid is allowed.
- Arbitration (combinational):
  - The search starts at rr_ptr and goes upward, wrapping modulo N_REQ. The first valid requester is granted.
  - At most one bit of req_ready is high.
  - hold=1 or reset=1 forces req_ready=0.
- Pointer update: on a transfer from requester i, rr_ptr <= (i+1) mod N_REQ. With no transfer, rr_ptr is unchanged.
- Write port:
  - Latency is 1 cycle. A transfer in cycle t gives wr_en=1 in cycle t+1, with the granted addr/data captured in cycle t.
  - With no transfer, wr_en=0 and wr_addr/wr_data hold their last values.
  - Throughput is one write per cycle.
- Scoreboard:
  - rsv_en sets pending[rsv_addr] on the next edge.
  - A cycle with wr_en=1 clears pending[wr_addr] on the next edge.
  - Simultaneous set and clear of the same register: set wins, because the newer reservation stays outstanding.
  - Different registers update independently in the same cycle.
  - A write to a non-pending register is legal and leaves pending unchanged.
- Fairness: with all N_REQ requesters continuously valid and hold=0, each is granted exactly once every N_REQ cycles.
- Reset mid-operation:
  - An in-flight registered write is discarded; wr_en=0 next cycle.
  - The scoreboard clears and the pointer returns to 0.
  - Requesters must re-present their requests.

Optional Feature:
- Macro REGWR_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt of width N_REQ*16. Each 16-bit counter increments on every transfer of its requester and saturates at 16'hFFFF.
  - Adds output conflict_cnt, 16 bits. It increments, saturating, in every cycle where at least 2 requesters are valid and hold=0.
  - All counters reset to 0.
- When not defined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package regfile_pkg: DW, N_REGS, AW constants, the reg_addr_t and reg_data_t typedefs, and the requester index constants REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
- One sub-module: rr_arbiter. Parameter N; inputs req and ptr; output one-hot gnt. Pure combinational, reusable for the memory-port arbiter.
- Write-port register, pointer and scoreboard stay in the top module.

Test Plan:
- Reset then single request: req_valid=3'b010, addr=5, data=16'sh8001 → req_ready=3'b010 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=16'h8001; rr_ptr becomes 2.
- All three requesters valid for 6 cycles from rr_ptr=0, hold=0 → grant order 0,1,2,0,1,2 and six consecutive wr_en pulses.
- hold=1 with req_valid=3'b111 for 3 cycles → req_ready=0 and wr_en=0 throughout; grant to requester 0 in the cycle after hold falls.
- Scoreboard: rsv_en addr 3 → pending=8'h08. Then a write to 3 with a simultaneous rsv_en to 3 → pending stays 8'h08. A later write to 3 alone → pending=8'h00.
- Reset asserted in the cycle after a transfer → wr_en=0 next cycle, pending=0, the next grant starts from requester 0.
- With REGWR_ARB_STATS_EN: 4 cycles of req_valid=3'b011 → grant_cnt[0]=2, grant_cnt[1]=2, conflict_cnt=4.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-bank definitions.
// Contents: bank geometry (DW, N_REGS, AW), address/data typedefs and the
// fixed requester index assignment used by the write-port arbiter.
package regfile_pkg;
  localparam int DW     = 16;
  localparam int N_REGS = 8;
  localparam int AW     = 3;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req [N] request vector, ptr [PW] highest-priority index,
//        gnt [N] one-hot grant (all zero when no request).
// The search starts at ptr and goes upward, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-bank write-port arbiter with pending-write scoreboard.
// Ports: clk, reset (sync, active-high), hold (no grant while high),
//   req_valid/req_addr/req_data  per-requester write requests,
//   req_ready  combinational one-hot grant,
//   wr_en/wr_addr/wr_data  registered write port (1-cycle latency),
//   rsv_en/rsv_addr  issue-time reservation, pending  per-register scoreboard.
// Optional (REGWR_ARB_STATS_EN): grant_cnt (16 bits per requester) and
//   conflict_cnt, saturating statistics counters.
import regfile_pkg::*;

module regfile_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int N_REGS = regfile_pkg::N_REGS,
  parameter int AW     = regfile_pkg::AW,
  parameter int DW     = regfile_pkg::DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [N_REGS-1:0]   pending
`ifdef REGWR_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] grant_cnt,
  output logic [15:0]         conflict_cnt
`endif
);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d, nxt_ptr;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d, sel_addr;
  logic [DW-1:0]     wr_data_q, wr_data_d, sel_data;
  logic [N_REGS-1:0] pending_q, pending_d;
  logic [N_REQ-1:0]  gnt, xfer_vec;
  logic              xfer;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign req_ready = (reset || hold) ? '0 : gnt;
  assign xfer_vec  = req_valid & req_ready;
  assign xfer      = |xfer_vec;

  // One-hot grant to selected addr/data and the pointer past the winner.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    nxt_ptr  = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer_vec[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
        nxt_ptr  = PW'((i + 1) % N_REQ);
      end
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = xfer;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      rr_ptr_d  = nxt_ptr;
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
    // Set is applied after clear so a fresh reservation of the register
    // being written stays outstanding.
    pending_d = pending_q;
    if (wr_en_q) pending_d[wr_addr_q] = 1'b0;
    if (rsv_en)  pending_d[rsv_addr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;

`ifdef REGWR_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] grant_cnt_q;
  logic [15:0]            conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (xfer_vec[i] && grant_cnt_q[i] != 16'hFFFF)
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      if (!hold && $countones(req_valid) >= 2 && conflict_cnt_q != 16'hFFFF)
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign grant_cnt    = grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: table of per-cycle stimulus with the
// expected grant, plus a write-port scoreboard queue and a pending model.
module tb_regfile_write_arbiter;
  localparam int N_REQ = 3, N_REGS = 8, AW = 3, DW = 16;

  logic                clk = 1'b0;
  logic                reset, hold, rsv_en, wr_en;
  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [AW-1:0]       wr_addr, rsv_addr;
  logic [DW-1:0]       wr_data;
  logic [N_REGS-1:0]   pending;
`ifdef REGWR_ARB_STATS_EN
  logic [N_REQ*16-1:0] grant_cnt;
  logic [15:0]         conflict_cnt;
`endif

  regfile_write_arbiter #(.N_REQ(N_REQ), .N_REGS(N_REGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending)
`ifdef REGWR_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       hold;
    bit [2:0] vld;
    bit [8:0] addrs;   // {a2, a1, a0}
    bit       rsv;
    bit [2:0] raddr;
    bit [2:0] exp_rdy;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         last_w;
  logic [7:0]  m_pend;
  vec_t        tbl[31];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dat(input int r, input int i);
    return 16'h8000 | 16'(r << 4) | 16'(i);
  endfunction

  function automatic vec_t mk(input bit rst, input bit hld, input bit [2:0] vld,
                              input bit [8:0] addrs, input bit rsv,
                              input bit [2:0] raddr, input bit [2:0] rdy);
    vec_t v;
    v.rst = rst; v.hold = hld; v.vld = vld; v.addrs = addrs;
    v.rsv = rsv; v.raddr = raddr; v.exp_rdy = rdy;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int r);
    reset     = v.rst;
    hold      = v.hold;
    req_valid = v.vld;
    req_addr  = v.addrs;
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = dat(r, i);
    rsv_en    = v.rsv;
    rsv_addr  = v.raddr;
  endtask

  // Check the cycle at the falling edge, then advance the model past the
  // next rising edge.
  task automatic observe(input vec_t v, input int r);
    wr_t w, nw;
    bit  had_wr;
    had_wr = 1'b0;
    w = last_w;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      had_wr = 1'b1;
      last_w = w;
      chk($sformatf("r%0d wr_en", r), 32'(wr_en), 32'd1);
      chk($sformatf("r%0d wr_addr", r), 32'(wr_addr), 32'(w.addr));
      chk($sformatf("r%0d wr_data", r), 32'(wr_data), 32'(w.data));
    end else begin
      chk($sformatf("r%0d wr_en", r), 32'(wr_en), 32'd0);
      chk($sformatf("r%0d wr_addr_hold", r), 32'(wr_addr), 32'(last_w.addr));
      chk($sformatf("r%0d wr_data_hold", r), 32'(wr_data), 32'(last_w.data));
    end
    chk($sformatf("r%0d pending", r), 32'(pending), 32'(m_pend));
    chk($sformatf("r%0d req_ready", r), 32'(req_ready), 32'(v.exp_rdy));
    for (int i = 0; i < N_REQ; i++)
      if (v.vld[i] && v.exp_rdy[i]) begin
        nw.addr = v.addrs[i*3 +: 3];
        nw.data = dat(r, i);
        exp_q.push_back(nw);
      end
    if (v.rst) begin
      m_pend = '0;
      exp_q.delete();
      last_w.addr = '0;
      last_w.data = '0;
    end else begin
      if (had_wr) m_pend[w.addr] = 1'b0;
      if (v.rsv)  m_pend[v.raddr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst hold vld     addrs   rsv raddr  exp_rdy
    tbl[0]  = mk(0, 0, 3'b010, 9'o050, 0, 3'd0, 3'b010); // single LSU write, ptr->2
    tbl[1]  = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
    tbl[2]  = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b100); // proves ptr==2
    tbl[3]  = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b001); // fairness 0,1,2,0,1,2
    tbl[4]  = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b010);
    tbl[5]  = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b100);
    tbl[6]  = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b001);
    tbl[7]  = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b010);
    tbl[8]  = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b100);
    tbl[9]  = mk(0, 1, 3'b111, 9'o124, 0, 3'd0, 3'b000); // hold
    tbl[10] = mk(0, 1, 3'b111, 9'o124, 0, 3'd0, 3'b000);
    tbl[11] = mk(0, 1, 3'b111, 9'o124, 0, 3'd0, 3'b000);
    tbl[12] = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b001); // hold released
    tbl[13] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
    tbl[14] = mk(0, 0, 3'b000, 9'o124, 1, 3'd3, 3'b000); // reserve r3
    tbl[15] = mk(0, 0, 3'b001, 9'o003, 0, 3'd0, 3'b001); // write r3
    tbl[16] = mk(0, 0, 3'b000, 9'o124, 1, 3'd3, 3'b000); // clear+set r3: set wins
    tbl[17] = mk(0, 0, 3'b100, 9'o300, 0, 3'd0, 3'b100); // write r3 again
    tbl[18] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
    tbl[19] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000); // pending==0
    tbl[20] = mk(0, 0, 3'b000, 9'o124, 1, 3'd6, 3'b000);
    tbl[21] = mk(0, 0, 3'b010, 9'o060, 0, 3'd0, 3'b010); // write r6
    tbl[22] = mk(0, 0, 3'b000, 9'o124, 1, 3'd2, 3'b000); // clear r6, set r2
    tbl[23] = mk(0, 0, 3'b001, 9'o007, 0, 3'd0, 3'b001); // write non-pending r7
    tbl[24] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
    tbl[25] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
    tbl[26] = mk(0, 0, 3'b010, 9'o010, 0, 3'd0, 3'b010); // transfer, ptr->2
    tbl[27] = mk(1, 0, 3'b111, 9'o124, 0, 3'd0, 3'b000); // reset mid-op
    tbl[28] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
    tbl[29] = mk(0, 0, 3'b111, 9'o124, 0, 3'd0, 3'b001); // restart from req 0
    tbl[30] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);

    m_pend = '0;
    last_w.addr = '0;
    last_w.data = '0;
    reset = 1'b1; hold = 1'b0; req_valid = 3'b111; req_addr = '0; req_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    chk("reset wr_data", 32'(wr_data), 32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 31; r++) begin
      apply(tbl[r], r);
      observe(tbl[r], r);
    end

`ifdef REGWR_ARB_STATS_EN
    begin
      vec_t s[6];
      s[0] = mk(1, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
      s[1] = mk(0, 0, 3'b011, 9'o124, 0, 3'd0, 3'b001);
      s[2] = mk(0, 0, 3'b011, 9'o124, 0, 3'd0, 3'b010);
      s[3] = mk(0, 0, 3'b011, 9'o124, 0, 3'd0, 3'b001);
      s[4] = mk(0, 0, 3'b011, 9'o124, 0, 3'd0, 3'b010);
      s[5] = mk(0, 0, 3'b000, 9'o124, 0, 3'd0, 3'b000);
      for (int k = 0; k < 6; k++) begin
        apply(s[k], 40 + k);
        observe(s[k], 40 + k);
      end
      chk("grant_cnt0", 32'(grant_cnt[15:0]), 32'd2);
      chk("grant_cnt1", 32'(grant_cnt[31:16]), 32'd2);
      chk("grant_cnt2", 32'(grant_cnt[47:32]), 32'd0);
      chk("conflict_cnt", 32'(conflict_cnt), 32'd4);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
